// File: rtl/mipsfpga_dma_regs.sv
// AHB-Lite slave holding the DMA descriptor registers and start handshake.
// The CPU fills the descriptor and sets START; the engine reads it back and pulses CLEAR_START.
module mipsfpga_dma_regs #(
  parameter int WAIT_STATES = 0,
  parameter int SIZE_MAX    = 256
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        DMA_INTERRUPT,
  input  logic        CLEAR_START
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  localparam logic [2:0] WAIT_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
  localparam logic [8:0] SIZE_SAT  = 9'(SIZE_MAX);

  state_t      state_reg, state_next;
  logic [2:0]  addr_reg, addr_next;
  logic        write_reg, write_next;
  logic [2:0]  wcnt_reg, wcnt_next;

  logic [8:0]  size_reg;
  logic [31:0] src_reg, dst_reg, keyhi_reg, keylo_reg;
  logic [1:0]  ed_reg;
  logic        start_reg, start_next;
  logic        busy_reg, busy_next;

  logic        accept, bad, commit, ctrl_wr;
  logic [31:0] rd_mux;
  logic        unused_bits;

  assign accept  = HSEL & HREADY & HTRANS[1];
  // STATUS (word 7) is read-only, so a write there is an error rather than a silent drop.
  assign bad     = (HADDR[1:0] != 2'b00) | (HSIZE != 3'b010) | (HWRITE & (HADDR[4:2] == 3'd7));
  assign commit  = (state_reg == S_DATA) & write_reg;
  assign ctrl_wr = commit & (addr_reg == 3'd6);
  assign unused_bits = ^{HADDR[31:5], HTRANS[0]};

  // Set wins over a simultaneous engine acknowledge.
  assign start_next = (ctrl_wr & HWDATA[0]) | (start_reg & ~CLEAR_START);
  assign busy_next  = CLEAR_START | (busy_reg & ~(ctrl_wr & HWDATA[1]));
  assign DMA_INTERRUPT = start_reg;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    write_next = write_reg;
    wcnt_next  = wcnt_reg;
    HREADYOUT  = 1'b1;
    HRESP      = 1'b0;
    case (state_reg)
      S_IDLE, S_DATA: begin
        state_next = S_IDLE;
        if (accept) begin
          addr_next  = HADDR[4:2];
          write_next = HWRITE;
          wcnt_next  = 3'd0;
          if (bad)
            state_next = S_ERR1;
          else
            state_next = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
        end
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (wcnt_reg == WAIT_LAST)
          state_next = S_DATA;
        else
          wcnt_next = wcnt_reg + 3'd1;
      end
      S_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = S_ERR2;
      end
      S_ERR2: begin
        HRESP      = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr_reg)
      3'd0: rd_mux = {23'd0, size_reg};
      3'd1: rd_mux = src_reg;
      3'd2: rd_mux = dst_reg;
      3'd3: rd_mux = {30'd0, ed_reg};
      3'd4: rd_mux = keyhi_reg;
      3'd5: rd_mux = keylo_reg;
      3'd6: rd_mux = {31'd0, start_reg};
      3'd7: rd_mux = {30'd0, busy_reg, start_reg};
      default: rd_mux = 32'd0;
    endcase
    HRDATA = ((state_reg == S_DATA) && !write_reg) ? rd_mux : 32'd0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_reg <= S_IDLE;
      addr_reg  <= 3'd0;
      write_reg <= 1'b0;
      wcnt_reg  <= 3'd0;
      size_reg  <= 9'd0;
      src_reg   <= 32'd0;
      dst_reg   <= 32'd0;
      ed_reg    <= 2'd0;
      keyhi_reg <= 32'd0;
      keylo_reg <= 32'd0;
      start_reg <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      write_reg <= write_next;
      wcnt_reg  <= wcnt_next;
      start_reg <= start_next;
      busy_reg  <= busy_next;
      if (commit) begin
        case (addr_reg)
          3'd0: size_reg  <= (HWDATA > 32'(SIZE_MAX)) ? SIZE_SAT : HWDATA[8:0];
          3'd1: src_reg   <= HWDATA;
          3'd2: dst_reg   <= HWDATA;
          3'd3: ed_reg    <= HWDATA[1:0];
          3'd4: keyhi_reg <= HWDATA;
          3'd5: keylo_reg <= HWDATA;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mipsfpga_dma_regs.sv
// Randomized self-checking bench for mipsfpga_dma_regs, one instance with no wait states and one with two.
module tb_mipsfpga_dma_regs;

  logic        HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET, HSEL, HWRITE, CLEAR_START, use2;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  logic [31:0] rdata0, rdata2;
  logic        rdy0, rdy2, resp0, resp2, irq0, irq2;
  logic        hsel0, hsel2, clr0, clr2, hready, hresp, irq;
  logic [31:0] hrdata;

  assign hsel0  = HSEL & ~use2;
  assign hsel2  = HSEL & use2;
  assign clr0   = CLEAR_START & ~use2;
  assign clr2   = CLEAR_START & use2;
  assign hready = use2 ? rdy2 : rdy0;
  assign hresp  = use2 ? resp2 : resp0;
  assign hrdata = use2 ? rdata2 : rdata0;
  assign irq    = use2 ? irq2 : irq0;

  mipsfpga_dma_regs #(.WAIT_STATES(0), .SIZE_MAX(256)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(hready),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0), .DMA_INTERRUPT(irq0),
    .CLEAR_START(clr0));

  mipsfpga_dma_regs #(.WAIT_STATES(2), .SIZE_MAX(256)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(hready),
    .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2), .DMA_INTERRUPT(irq2),
    .CLEAR_START(clr2));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: register contents as seen by a reader, plus START/busy flags.
  logic [31:0] m_reg [2][8];
  bit          m_start [2];
  bit          m_busy [2];
  int          ws_of [2] = '{0, 2};

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int o = 0; o < 8; o++) m_reg[d][o] = 32'd0;
      m_start[d] = 0;
      m_busy[d]  = 0;
    end
  endtask

  function automatic logic [31:0] m_read(int d, int off);
    case (off)
      6: return {31'd0, m_start[d]};
      7: return {30'd0, m_busy[d], m_start[d]};
      default: return m_reg[d][off];
    endcase
  endfunction

  task automatic m_write(int d, int off, logic [31:0] v, bit clr);
    if (clr) m_start[d] = 0;
    case (off)
      0: m_reg[d][0] = (v > 32'd256) ? 32'd256 : v;
      3: m_reg[d][3] = v & 32'h3;
      6: begin
        if (v[0]) m_start[d] = 1;
        if (v[1]) m_busy[d] = 0;
      end
      7: ;
      default: m_reg[d][off] = v;
    endcase
    if (clr) m_busy[d] = 1;
  endtask

  // One non-pipelined transfer; returns the data, wait cycles and ERROR indications seen.
  task automatic do_xfer(input bit w, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                         input bit clr, output logic [31:0] rd, output int lows, output bit resp_lo, output bit resp_hi);
    HSEL = 1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz;
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00; HWDATA = wd; CLEAR_START = clr;
    lows = 0; resp_lo = 0;
    while (!hready && lows < 16) begin
      resp_lo |= hresp;
      lows++;
      @(posedge HCLK); #1;
    end
    rd = hrdata; resp_hi = hresp;
    @(posedge HCLK); #1;
    CLEAR_START = 0;
  endtask

  task automatic wr(int d, int off, logic [31:0] v);
    logic [31:0] rd; int lows; bit rl, rh;
    use2 = (d != 0);
    do_xfer(1, 32'(off * 4), 3'b010, v, 0, rd, lows, rl, rh);
    m_write(d, off, v, 0);
  endtask

  task automatic rdreg(int d, int off, output logic [31:0] rd, output int lows);
    bit rl, rh;
    use2 = (d != 0);
    do_xfer(0, 32'(off * 4), 3'b010, 32'd0, 0, rd, lows, rl, rh);
  endtask

  task automatic pulse_clear(int d);
    use2 = (d != 0);
    CLEAR_START = 1;
    @(posedge HCLK); #1;
    CLEAR_START = 0;
    m_start[d] = 0;
    m_busy[d]  = 1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lows;
    for (int d = 0; d < 2; d++) begin
      use2 = (d != 0);
      vectors++; if (hready !== 1'b1) begin miscompares++; $display("FAIL reset_hreadyout dut%0d got %b want 1", d, hready); end
      vectors++; if (hresp !== 1'b0) begin miscompares++; $display("FAIL reset_hresp dut%0d got %b want 0", d, hresp); end
      vectors++; if (hrdata !== 32'd0) begin miscompares++; $display("FAIL reset_hrdata dut%0d got %h want 0", d, hrdata); end
      vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq dut%0d got %b want 0", d, irq); end
    end
    for (int o = 0; o < 8; o++) begin
      rdreg(0, o, rd, lows);
      vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL reset_read off%0h got %h want 0", o * 4, rd); end
    end
  endtask

  task automatic test_registers();
    logic [31:0] vals [6] = '{32'd16, 32'h8000_0000, 32'h8000_1000, 32'd1, 32'h0123_4567, 32'h89AB_CDEF};
    logic [31:0] rd, v; int lows, off; bit w;
    for (int o = 0; o < 6; o++) wr(0, o, vals[o]);
    for (int o = 0; o < 6; o++) begin
      rdreg(0, o, rd, lows);
      vectors++; if (rd !== vals[o]) begin miscompares++; $display("FAIL readback off%0h got %h want %h", o * 4, rd, vals[o]); end
      vectors++; if (lows !== 0) begin miscompares++; $display("FAIL readback_waits off%0h got %0d want 0", o * 4, lows); end
    end
    wr(0, 0, 32'd300);
    rdreg(0, 0, rd, lows);
    vectors++; if (rd !== 32'd256) begin miscompares++; $display("FAIL size_saturate got %0d want 256", rd); end
    for (int i = 0; i < 40; i++) begin
      off = $urandom_range(0, 7);
      w = $urandom_range(0, 1) == 1 && off != 7;
      v = $urandom;
      if (off == 0 && $urandom_range(0, 1) == 1) v = $urandom_range(0, 300);
      if (w) begin
        wr(0, off, v);
      end else begin
        rdreg(0, off, rd, lows);
        vectors++; if (rd !== m_read(0, off)) begin miscompares++; $display("FAIL rand_read off%0h got %h want %h", off * 4, rd, m_read(0, off)); end
      end
      vectors++; if (irq0 !== m_start[0]) begin miscompares++; $display("FAIL rand_irq got %b want %b", irq0, m_start[0]); end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; int lows; bit rl, rh;
    logic [31:0] sv = 32'($urandom_range(0, 256));
    logic [31:0] av = $urandom;
    wr(1, 0, sv);
    use2 = 1;
    do_xfer(1, 32'h4, 3'b010, av, 0, rd, lows, rl, rh);
    m_write(1, 1, av, 0);
    vectors++; if (lows !== 2 || rh !== 1'b0) begin miscompares++; $display("FAIL ws_write_waits got %0d/%b want 2/0", lows, rh); end
    HSEL = 1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 0; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HADDR = 32'h4;
    lows = 0;
    while (!hready && lows < 16) begin lows++; @(posedge HCLK); #1; end
    vectors++; if (lows !== 2) begin miscompares++; $display("FAIL ws_pipe_a_waits got %0d want 2", lows); end
    vectors++; if (hrdata !== m_read(1, 0)) begin miscompares++; $display("FAIL ws_pipe_a_data got %h want %h", hrdata, m_read(1, 0)); end
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00;
    lows = 0;
    while (!hready && lows < 16) begin lows++; @(posedge HCLK); #1; end
    vectors++; if (lows !== 2) begin miscompares++; $display("FAIL ws_pipe_b_waits got %0d want 2", lows); end
    vectors++; if (hrdata !== m_read(1, 1)) begin miscompares++; $display("FAIL ws_pipe_b_data got %h want %h", hrdata, m_read(1, 1)); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    use2 = 0;
    for (int off = 1; off <= 2; off++) begin
      v = $urandom;
      HSEL = 1; HTRANS = 2'b10; HADDR = 32'(off * 4); HWRITE = 1; HSIZE = 3'b010;
      @(posedge HCLK); #1;
      HWRITE = 0; HWDATA = v;
      m_write(0, off, v, 0);
      vectors++; if (hready !== 1'b1) begin miscompares++; $display("FAIL b2b_write_ready off%0h got %b want 1", off * 4, hready); end
      @(posedge HCLK); #1;
      HSEL = 0; HTRANS = 2'b00;
      vectors++; if (hrdata !== v || hready !== 1'b1) begin miscompares++; $display("FAIL b2b_read off%0h got %h want %h", off * 4, hrdata, v); end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_start();
    logic [31:0] rd; int lows; bit rl, rh;
    pulse_clear(0);
    wr(0, 6, 32'd2);
    vectors++; if (irq0 !== 1'b0) begin miscompares++; $display("FAIL start_idle_irq got %b want 0", irq0); end
    wr(0, 6, 32'd1);
    vectors++; if (irq0 !== 1'b1) begin miscompares++; $display("FAIL start_irq_rise got %b want 1", irq0); end
    rdreg(0, 6, rd, lows);
    vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL start_ctrl_read got %h want 1", rd); end
    pulse_clear(0);
    vectors++; if (irq0 !== 1'b0) begin miscompares++; $display("FAIL start_irq_fall got %b want 0", irq0); end
    rdreg(0, 7, rd, lows);
    vectors++; if (rd !== 32'd2) begin miscompares++; $display("FAIL status_busy got %h want 2", rd); end
    wr(0, 6, 32'd2);
    rdreg(0, 7, rd, lows);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL status_ack got %h want 0", rd); end
    use2 = 0;
    do_xfer(1, 32'h18, 3'b010, 32'd1, 1, rd, lows, rl, rh);
    m_write(0, 6, 32'd1, 1);
    vectors++; if (irq0 !== 1'b1) begin miscompares++; $display("FAIL set_wins_irq got %b want 1", irq0); end
    rdreg(0, 7, rd, lows);
    vectors++; if (rd !== 32'd3) begin miscompares++; $display("FAIL set_wins_status got %h want 3", rd); end
    pulse_clear(0);
    wr(0, 6, 32'd2);
  endtask

  task automatic test_errors();
    bit          ew [5]  = '{0, 0, 1, 1, 1};
    logic [31:0] ea [5]  = '{32'h06, 32'h00, 32'h1C, 32'h04, 32'h18};
    logic [2:0]  es [5]  = '{3'b010, 3'b001, 3'b010, 3'b001, 3'b000};
    logic [31:0] rd; int lows; bit rl, rh;
    for (int d = 0; d < 2; d++) begin
      use2 = (d != 0);
      for (int i = 0; i < 5; i++) begin
        do_xfer(ew[i], ea[i], es[i], $urandom | 32'h3, 0, rd, lows, rl, rh);
        vectors++;
        if (lows !== 1 || rl !== 1'b1 || rh !== 1'b1 || rd !== 32'd0)
          begin miscompares++; $display("FAIL err_resp dut%0d case%0d got waits=%0d resp=%b%b data=%h want 1/11/0", d, i, lows, rl, rh, rd); end
      end
      for (int o = 0; o < 8; o++) begin
        rdreg(d, o, rd, lows);
        vectors++; if (rd !== m_read(d, o)) begin miscompares++; $display("FAIL err_unchanged dut%0d off%0h got %h want %h", d, o * 4, rd, m_read(d, o)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lows;
    wr(1, 1, $urandom | 32'h1);
    use2 = 1;
    HSEL = 1; HTRANS = 2'b10; HADDR = 32'h4; HWRITE = 1; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HSEL = 0; HTRANS = 2'b00; HWDATA = $urandom | 32'h1;
    vectors++; if (hready !== 1'b0) begin miscompares++; $display("FAIL midreset_in_wait got %b want 0", hready); end
    HRESET = 1;
    @(posedge HCLK); #1;
    HRESET = 0;
    m_reset();
    vectors++; if (hready !== 1'b1 || hresp !== 1'b0) begin miscompares++; $display("FAIL midreset_ready got %b/%b want 1/0", hready, hresp); end
    rdreg(1, 1, rd, lows);
    vectors++; if (rd !== 32'd0) begin miscompares++; $display("FAIL midreset_src got %h want 0", rd); end
    rdreg(0, 0, rd, lows);
    vectors++; if (rd !== m_read(0, 0)) begin miscompares++; $display("FAIL midreset_size got %h want %h", rd, m_read(0, 0)); end
  endtask

  initial begin
    HRESET = 1; HSEL = 0; HTRANS = 2'b00; HADDR = 32'd0; HWRITE = 0; HSIZE = 3'b010;
    HWDATA = 32'd0; CLEAR_START = 0; use2 = 0;
    m_reset();
    repeat (3) @(posedge HCLK);
    #1 HRESET = 0;
    test_reset();
    test_registers();
    test_wait_states();
    test_back_to_back();
    test_start();
    test_errors();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mipsfpga_dma_regs.md
# mipsfpga_dma_regs

AHB-Lite slave holding the DMA engine's descriptor registers (size, source, destination, encrypt/decrypt mode, DES key) and its start request. The CPU writes a descriptor and sets START; the block raises `DMA_INTERRUPT`; the DMA engine, acting as bus master, reads the descriptor back over the same bus and pulses `CLEAR_START`. The block sits on the AHB-Lite decoder at base `0x1F30_0000`, occupying offsets `0x00`–`0x1C`.

## Interface
- `WAIT_STATES`, default 0: extra `HREADYOUT`-low cycles inserted in every OKAY data phase (0–7).
- `SIZE_MAX`, default 256: maximum transfer length in words. Matches the engine FIFO depth.
- `HCLK  in  1`: the single clock.
- `HRESET  in  1`: synchronous, active-high reset.
- `HSEL  in  1`: slave select from the decoder.
- `HADDR  in  32`: address. Only `[4:0]` is decoded.
- `HTRANS  in  2`: transfer type. `HTRANS[1]=1` means NONSEQ or SEQ.
- `HWRITE  in  1`: 1 = write.
- `HSIZE  in  3`: must be `3'b010` (word).
- `HWDATA  in  32`: write data, sampled in the data phase.
- `HREADY  in  1`: bus-wide ready.
- `HRDATA  out  32`: read data.
- `HREADYOUT  out  1`: slave ready.
- `HRESP  out  1`: 0 = OKAY, 1 = ERROR.
- `DMA_INTERRUPT  out  1`: start request level to the DMA engine.
- `CLEAR_START  in  1`: one-cycle pulse from the engine that acknowledges the start.

## Operation
- Register map (offset):
  - `0x00` SIZE: 9 bits. A written value greater than `SIZE_MAX` saturates to `SIZE_MAX`.
  - `0x04` SRC: 32 bits.
  - `0x08` DST: 32 bits.
  - `0x0C` ED: 2 bits. 0 = plain copy, nonzero = DES.
  - `0x10` KEYHI: 32 bits.
  - `0x14` KEYLO: 32 bits.
  - `0x18` CTRL: write bit0=1 sets START. Reads return `{31'b0, START}`.
  - `0x1C` STATUS: read-only `{30'b0, busy, START}`.
  - Unused read bits are 0.
- `busy`:
  - Set by `CLEAR_START`.
  - Cleared by a CPU write to CTRL with bit1=1 (completion acknowledge).
  - Not otherwise cleared, except by reset.
- `DMA_INTERRUPT` equals START, registered.
- START:
  - Set by a CTRL write with bit0=1.
  - Cleared by `CLEAR_START`.
  - If the set and the clear occur in the same cycle, the set wins.
- Address phase is accepted when `HSEL & HREADY & HTRANS[1]`. Address, direction and size are latched.
- Error conditions, each giving a two-cycle ERROR response:
  - `HADDR[1:0]≠0`.
  - `HSIZE≠3'b010`.
  - A write to STATUS.
  - In each case no register changes and `HRDATA=0`.
- FSM states:
  - IDLE: `HREADYOUT=1`, `HRESP=0`. An accepted OKAY transfer goes to WAIT if `WAIT_STATES>0`, else to DATA. An accepted erroneous transfer goes to ERR1.
  - WAIT: `HREADYOUT=0`. Counts `WAIT_STATES` cycles, then goes to DATA.
  - DATA: `HREADYOUT=1`.
    - Writes commit `HWDATA` at the end of this cycle.
    - Reads present `HRDATA` this cycle.
    - A new accepted transfer in this cycle is pipelined: go to WAIT, DATA or ERR1 directly. Otherwise go to IDLE.
  - ERR1: `HREADYOUT=0`, `HRESP=1`. Goes to ERR2.
  - ERR2: `HREADYOUT=1`, `HRESP=1`. Goes to IDLE. Any address phase presented here is ignored; the master cancels on ERROR.
- `HSEL=0`, or IDLE/BUSY `HTRANS`, while `HREADY=1` leaves the FSM in IDLE with an OKAY zero-wait response.

## Timing
- Reset (synchronous, `HRESET=1` at a `HCLK` edge):
  - All registers are 0, START=0, busy=0, FSM in IDLE.
  - `HRDATA=0`, `HREADYOUT=1`, `HRESP=0`, `DMA_INTERRUPT=0`.
  - Reset mid-transfer abandons the transfer; no partial write.
- Read latency with `WAIT_STATES=0`:
  - Address phase in cycle N; `HRDATA` valid in cycle N+1 with `HREADYOUT=1`.
  - With W wait states, data is valid in cycle N+1+W.
- Write: the register updates at the rising edge ending the last data-phase cycle. A read of the same register in the next data phase returns the new value (back-to-back write→read, no hazard).
- `DMA_INTERRUPT` rises one cycle after the CTRL write's data phase completes. It falls one cycle after `CLEAR_START`.
- The ERROR response is exactly 2 cycles regardless of `WAIT_STATES`.

## Test plan
- Reset → every offset reads 0. `HREADYOUT=1`, `HRESP=0`, `DMA_INTERRUPT=0`.
- Write SIZE=16, SRC=`0x8000_0000`, DST=`0x8000_1000`, ED=1, KEYHI=`0x0123_4567`, KEYLO=`0x89AB_CDEF`, then read each back → all values match. SIZE=300 reads back 256.
- With `WAIT_STATES=2`, pipelined read SIZE followed by read SRC → each data phase has `HREADYOUT` low for 2 cycles, then correct data; no address is dropped.
- Write CTRL=1 → `DMA_INTERRUPT` high next cycle. Pulse `CLEAR_START` → `DMA_INTERRUPT` low and STATUS=`0b10`. Write CTRL=2 → STATUS=0. CTRL=1 written in the same cycle as `CLEAR_START` → START stays 1.
- Read at offset `0x06`, read with `HSIZE=3'b001`, and write to STATUS → each gets ERR1/ERR2 (`HRESP=1` for 2 cycles, `HREADYOUT` 0 then 1), and all registers are unchanged.
- Assert `HRESET` during the WAIT state of a write to SRC → SRC=0, `HREADYOUT=1` in the next cycle.
